// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS token constants, offset sizing and data-symbol decode
package tmds_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

    localparam int               OFFSET_W    = 4;
    localparam logic [OFFSET_W-1:0] OFFSET_LAST = 4'd9;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tmds_state_e;

    typedef struct packed {
        logic       is_ctrl;
        logic [1:0] code;
    } tmds_ctrl_t;

    function automatic tmds_ctrl_t tmds_classify(input logic [9:0] sym);
        tmds_ctrl_t t;
        t.is_ctrl = 1'b1;
        t.code    = 2'b00;
        case (sym)
            TMDS_CTRL_00: t.code = 2'b00;
            TMDS_CTRL_01: t.code = 2'b01;
            TMDS_CTRL_10: t.code = 2'b10;
            TMDS_CTRL_11: t.code = 2'b11;
            default:      t.is_ctrl = 1'b0;
        endcase
        return t;
    endfunction

    // Undo the encoder's optional inversion (bit9) and XOR/XNOR chaining (bit8).
    function automatic logic [7:0] tmds_decode_data(input logic [9:0] sym);
        logic [7:0] q;
        logic [7:0] d;
        q    = sym[9] ? ~sym[7:0] : sym[7:0];
        d    = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    function automatic logic [OFFSET_W-1:0] tmds_next_offset(input logic [OFFSET_W-1:0] off);
        return (off == OFFSET_LAST) ? '0 : off + 1'b1;
    endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// rtl/tmds_word_aligner.sv - two-word window register and bit-offset symbol mux
module tmds_word_aligner
    import tmds_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [9:0]          i_raw,
    input  logic [OFFSET_W-1:0] i_offset,
    output logic [9:0]          o_sym
);

    logic [9:0]  r_prev;
    logic [19:0] w_window;
    logic [19:0] w_shifted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_raw;
        end
    end

    // Older word sits in the low half so lower offsets select earlier bits.
    assign w_window  = {i_raw, r_prev};
    assign w_shifted = w_window >> i_offset;
    assign o_sym     = w_shifted[9:0];

endmodule

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - TMDS symbol aligner FSM and 10b->8b decoder with control-token lock
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN      = 8,
    parameter int SEARCH_CYCLES = 128,
    parameter int LOCK_TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] raw_i,
    output logic [7:0] data_o,
    output logic       de_o,
    output logic [1:0] ctrl_o,
    output logic       locked_o,
    output logic [3:0] slip_offset_o
);

    localparam int RUN_W     = $clog2(CTRL_RUN + 1);
    localparam int SEARCH_W  = $clog2(SEARCH_CYCLES + 1);
    localparam int TIMEOUT_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [RUN_W-1:0]     RUN_LAST     = RUN_W'(CTRL_RUN - 1);
    localparam logic [SEARCH_W-1:0]  SEARCH_LAST  = SEARCH_W'(SEARCH_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOCK_TIMEOUT - 1);

    tmds_state_e           r_state;
    logic [OFFSET_W-1:0]   r_offset;
    logic [RUN_W-1:0]      r_run;
    logic [SEARCH_W-1:0]   r_search;
    logic [TIMEOUT_W-1:0]  r_timeout;
    logic [7:0]            r_data;
    logic                  r_de;
    logic [1:0]            r_ctrl;
    logic                  r_locked;

    logic [9:0]            w_sym;
    tmds_ctrl_t            w_tok;

    tmds_word_aligner u_aligner (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_raw    (raw_i),
        .i_offset (r_offset),
        .o_sym    (w_sym)
    );

    assign w_tok = tmds_classify(w_sym);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_HUNT;
            r_offset  <= '0;
            r_run     <= '0;
            r_search  <= '0;
            r_timeout <= '0;
            r_data    <= '0;
            r_de      <= 1'b0;
            r_ctrl    <= '0;
            r_locked  <= 1'b0;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    r_de <= 1'b0;
                    // Lock takes priority over a search-timer expiry on the same cycle.
                    if (w_tok.is_ctrl && (r_run == RUN_LAST)) begin
                        r_state   <= ST_LOCKED;
                        r_locked  <= 1'b1;
                        r_timeout <= '0;
                        r_run     <= '0;
                        r_search  <= '0;
                    end else if (r_search == SEARCH_LAST) begin
                        r_offset <= tmds_next_offset(r_offset);
                        r_search <= '0;
                        r_run    <= '0;
                    end else begin
                        r_search <= r_search + 1'b1;
                        r_run    <= w_tok.is_ctrl ? r_run + 1'b1 : '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_tok.is_ctrl) begin
                        r_timeout <= '0;
                        r_de      <= 1'b0;
                        r_ctrl    <= w_tok.code;
                    end else if (r_timeout == TIMEOUT_LAST) begin
                        r_state   <= ST_HUNT;
                        r_locked  <= 1'b0;
                        r_de      <= 1'b0;
                        r_offset  <= tmds_next_offset(r_offset);
                        r_timeout <= '0;
                        r_search  <= '0;
                        r_run     <= '0;
                    end else begin
                        r_timeout <= r_timeout + 1'b1;
                        r_de      <= 1'b1;
                        r_data    <= tmds_decode_data(w_sym);
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    assign data_o        = r_data;
    assign de_o          = r_de;
    assign ctrl_o        = r_ctrl;
    assign locked_o      = r_locked;
    assign slip_offset_o = r_offset;

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - self-checking bench for tmds_decoder driven from a serial bitstream model
module tb_tmds_decoder;

    localparam int CTRL_RUN      = 4;
    localparam int SEARCH_CYCLES = 16;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int HUNT_BOUND    = 10 * SEARCH_CYCLES + CTRL_RUN + 2;

    logic       clk;
    logic       reset_n;
    logic [9:0] raw_i;
    logic [7:0] data_o;
    logic       de_o;
    logic [1:0] ctrl_o;
    logic       locked_o;
    logic [3:0] slip_offset_o;

    int checks = 0;
    int errors = 0;

    bit         bitq[$];
    logic [9:0] symq[$];
    bit         primed;
    logic [9:0] toks [4];

    tmds_decoder #(
        .CTRL_RUN      (CTRL_RUN),
        .SEARCH_CYCLES (SEARCH_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .raw_i         (raw_i),
        .data_o        (data_o),
        .de_o          (de_o),
        .ctrl_o        (ctrl_o),
        .locked_o      (locked_o),
        .slip_offset_o (slip_offset_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_is_token(input logic [9:0] s);
        return (s == 10'h354) || (s == 10'h0AB) || (s == 10'h154) || (s == 10'h2AB);
    endfunction

    function automatic logic [1:0] ref_token_code(input logic [9:0] s);
        case (s)
            10'h0AB: return 2'b01;
            10'h154: return 2'b10;
            10'h2AB: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] x;
        q = s[9] ? ~s[7:0] : s[7:0];
        x = q ^ {q[6:0], 1'b0};
        if (!s[8]) x = x ^ 8'hFE;
        return x;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] s;
        do s = 10'($urandom_range(0, 1023)); while (ref_is_token(s));
        return s;
    endfunction

    // Serial stream: k filler bits, then symbols LSB-first, chopped into 10-bit words.
    task automatic start_stream(input int k);
        bitq.delete();
        symq.delete();
        primed = 1'b0;
        for (int i = 0; i < k; i++) bitq.push_back(1'($urandom_range(0, 1)));
    endtask

    // The symbol judged at an edge is the one pushed one step earlier.
    task automatic step(input logic [9:0] sym, output bit has_eval, output logic [9:0] ev);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) bitq.push_back(sym[i]);
        symq.push_back(sym);
        for (int i = 0; i < 10; i++) w[i] = bitq.pop_front();
        raw_i = w;
        @(posedge clk);
        #1;
        if (primed) begin
            has_eval = 1'b1;
            ev       = symq.pop_front();
        end else begin
            has_eval = 1'b0;
            ev       = '0;
            primed   = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        raw_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic hunt(output int cycles, output bit got);
        bit         hv;
        logic [9:0] ev;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < HUNT_BOUND) begin
            step(10'h354, hv, ev);
            cycles++;
            if (locked_o === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit         hv;
        logic [9:0] ev;
        do_reset();
        checks++;
        if ({data_o, de_o, ctrl_o, locked_o, slip_offset_o} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0000", {data_o, de_o, ctrl_o, locked_o, slip_offset_o});
        end
        start_stream(0);
        step(10'h0FF, hv, ev);
        checks++;
        if ({data_o, de_o, ctrl_o, locked_o, slip_offset_o} !== 16'h0) begin
            errors++;
            $display("FAIL first_edge_after_release got %h want 0000", {data_o, de_o, ctrl_o, locked_o, slip_offset_o});
        end
    endtask

    task automatic test_lock_offset3();
        int cyc;
        bit got;
        do_reset();
        start_stream(3);
        hunt(cyc, got);
        checks++;
        if (!got || cyc > 3 * SEARCH_CYCLES + CTRL_RUN + 2) begin
            errors++;
            $display("FAIL lock3_time got locked=%0d after %0d cycles want lock within %0d", got, cyc, 3 * SEARCH_CYCLES + CTRL_RUN + 2);
        end
        checks++;
        if ({slip_offset_o, ctrl_o, de_o} !== {4'd3, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL lock3_state got off=%0d ctrl=%b de=%b want off=3 ctrl=00 de=0", slip_offset_o, ctrl_o, de_o);
        end
    endtask

    task automatic test_data_decode();
        int         cyc;
        bit         got;
        bit         hv;
        logic [9:0] ev;
        logic [9:0] syms [4];
        logic [7:0] expd [3];
        syms = '{10'h3FF, 10'h0FF, 10'h100, 10'h354};
        expd = '{8'h00, 8'hFF, 8'h00};
        do_reset();
        start_stream(0);
        hunt(cyc, got);
        checks++;
        if (!got || slip_offset_o !== 4'd0) begin
            errors++;
            $display("FAIL decode_lock got locked=%0d off=%0d want locked=1 off=0", got, slip_offset_o);
        end
        for (int i = 0; i < 4; i++) begin
            step(syms[i], hv, ev);
            if (i > 0) begin
                checks++;
                if ({de_o, data_o} !== {1'b1, expd[i-1]}) begin
                    errors++;
                    $display("FAIL decode_sym%0d got de=%b data=%h want de=1 data=%h", i - 1, de_o, data_o, expd[i-1]);
                end
            end
        end
    endtask

    task automatic test_ctrl_then_data();
        bit         hv;
        logic [9:0] ev;
        step(10'h2AB, hv, ev);
        step(10'h0FF, hv, ev);
        checks++;
        if ({ctrl_o, de_o} !== {2'b11, 1'b0}) begin
            errors++;
            $display("FAIL ctrl_token got ctrl=%b de=%b want ctrl=11 de=0", ctrl_o, de_o);
        end
        step(10'h354, hv, ev);
        checks++;
        if ({ctrl_o, de_o, data_o} !== {2'b11, 1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL ctrl_hold_data got ctrl=%b de=%b data=%h want ctrl=11 de=1 data=ff", ctrl_o, de_o, data_o);
        end
    endtask

    task automatic test_false_run();
        bit         hv;
        logic [9:0] ev;
        logic [9:0] s;
        int         total;
        do_reset();
        start_stream(0);
        total = 2 * CTRL_RUN + 1;
        for (int n = 1; n <= total; n++) begin
            s = (n == CTRL_RUN) ? rand_data() : toks[$urandom_range(0, 3)];
            step(s, hv, ev);
            checks++;
            if (locked_o !== (n == total)) begin
                errors++;
                $display("FAIL false_run_step%0d got locked=%b want %b", n, locked_o, (n == total));
            end
        end
        checks++;
        if (slip_offset_o !== 4'd0) begin
            errors++;
            $display("FAIL false_run_offset got %0d want 0", slip_offset_o);
        end
    endtask

    task automatic test_timeout();
        int         cyc;
        bit         got;
        bit         hv;
        logic [9:0] ev;
        int         n;
        do_reset();
        start_stream(9);
        hunt(cyc, got);
        checks++;
        if (!got || slip_offset_o !== 4'd9) begin
            errors++;
            $display("FAIL timeout_lock9 got locked=%0d off=%0d want locked=1 off=9", got, slip_offset_o);
        end
        n = 0;
        for (int i = 0; i < LOCK_TIMEOUT + 2 && n < LOCK_TIMEOUT; i++) begin
            step(rand_data(), hv, ev);
            if (!ref_is_token(ev)) n++;
            if (n < LOCK_TIMEOUT) begin
                if (locked_o !== 1'b1) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout_early_drop got locked=0 after %0d data want 1", n);
                end
            end else begin
                checks++;
                if ({locked_o, slip_offset_o} !== {1'b0, 4'd0}) begin
                    errors++;
                    $display("FAIL timeout_drop got locked=%b off=%0d want locked=0 off=0", locked_o, slip_offset_o);
                end
            end
        end
        checks++;
        if (n != LOCK_TIMEOUT) begin
            errors++;
            $display("FAIL timeout_count got %0d data symbols want %0d", n, LOCK_TIMEOUT);
        end
    endtask

    task automatic test_reset_mid_lock();
        int         cyc;
        bit         got;
        bit         hv;
        logic [9:0] ev;
        do_reset();
        start_stream(5);
        hunt(cyc, got);
        step(10'h0FF, hv, ev);
        step(10'h0FF, hv, ev);
        checks++;
        if ({locked_o, slip_offset_o, de_o, data_o} !== {1'b1, 4'd5, 1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL midlock_pre got lk=%b off=%0d de=%b data=%h want lk=1 off=5 de=1 data=ff", locked_o, slip_offset_o, de_o, data_o);
        end
        reset_n = 1'b0;
        #2;
        checks++;
        if ({data_o, de_o, ctrl_o, locked_o, slip_offset_o} !== 16'h0) begin
            errors++;
            $display("FAIL midlock_async_reset got %h want 0000", {data_o, de_o, ctrl_o, locked_o, slip_offset_o});
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        start_stream(2);
        step(10'h354, hv, ev);
        checks++;
        if ({locked_o, slip_offset_o} !== {1'b0, 4'd0}) begin
            errors++;
            $display("FAIL midlock_restart got lk=%b off=%0d want lk=0 off=0", locked_o, slip_offset_o);
        end
        hunt(cyc, got);
        checks++;
        if (!got || slip_offset_o !== 4'd2 || cyc + 1 > 2 * SEARCH_CYCLES + CTRL_RUN + 2) begin
            errors++;
            $display("FAIL midlock_relock got lk=%0d off=%0d cycles=%0d want lk=1 off=2 within %0d", got, slip_offset_o, cyc + 1, 2 * SEARCH_CYCLES + CTRL_RUN + 2);
        end
    endtask

    task automatic test_random_traffic();
        int         cyc;
        bit         got;
        bit         hv;
        logic [9:0] ev;
        logic [9:0] s;
        int         k;
        bit         lk;
        int         run;
        logic [7:0] exp_data;
        logic [1:0] exp_ctrl;
        logic       exp_de;
        for (int it = 0; it < 3; it++) begin
            k = $urandom_range(0, 9);
            do_reset();
            start_stream(k);
            hunt(cyc, got);
            checks++;
            if (!got || slip_offset_o !== 4'(k)) begin
                errors++;
                $display("FAIL rand_lock got lk=%0d off=%0d want lk=1 off=%0d", got, slip_offset_o, k);
            end
            lk       = got;
            run      = 0;
            exp_data = '0;
            exp_ctrl = '0;
            exp_de   = 1'b0;
            for (int i = 0; i < 150 && lk; i++) begin
                s = ($urandom_range(0, 3) == 0) ? toks[$urandom_range(0, 3)] : rand_data();
                step(s, hv, ev);
                if (ref_is_token(ev)) begin
                    run      = 0;
                    exp_de   = 1'b0;
                    exp_ctrl = ref_token_code(ev);
                end else begin
                    run++;
                    if (run == LOCK_TIMEOUT) begin
                        lk = 1'b0;
                    end else begin
                        exp_de   = 1'b1;
                        exp_data = ref_decode(ev);
                    end
                end
                checks++;
                if (lk) begin
                    if ({locked_o, de_o, ctrl_o, data_o} !== {1'b1, exp_de, exp_ctrl, exp_data}) begin
                        errors++;
                        $display("FAIL rand_stream sym=%h got lk=%b de=%b ctrl=%b data=%h want lk=1 de=%b ctrl=%b data=%h", ev, locked_o, de_o, ctrl_o, data_o, exp_de, exp_ctrl, exp_data);
                    end
                end else if ({locked_o, slip_offset_o} !== {1'b0, 4'((k + 1) % 10)}) begin
                    errors++;
                    $display("FAIL rand_timeout got lk=%b off=%0d want lk=0 off=%0d", locked_o, slip_offset_o, (k + 1) % 10);
                end
            end
        end
    endtask

    initial begin
        toks    = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        reset_n = 1'b0;
        raw_i   = '0;
        test_reset();
        test_lock_offset3();
        test_data_decode();
        test_ctrl_then_data();
        test_false_run();
        test_timeout();
        test_reset_mid_lock();
        test_random_traffic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
